bounce_gen: RTL and testbench

Synthesizable mechanical-contact emulator that sits in front of the button debouncer in self-test builds. The top level multiplexes it onto the debouncer's button input in place of the physical BUT1 pin. On request it drives a new level onto its output through a deterministic pseudo-random burst of contact bounces, then holds the level stable. It produces the waveform the debouncer consumes, so the on-board debounce path can be exercised without a human pressing the button.

---
 rtl/bounce_gen.sv | 145 ++++++++++++++
 tb/tb_bounce_gen.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// bounce_gen: emulates a mechanical contact. On request it walks o_BUT to a new level
// through a reproducible LFSR-timed burst of bounces, then holds it for a settle window.
module bounce_gen #(
   parameter int          BOUNCES       = 3,
   parameter int          GAP_BITS      = 12,
   parameter int          SETTLE_CYCLES = 300000,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       CLK,
   input  logic       i_RST,
   input  logic       i_Start,
   input  logic       i_Level,
   output logic       o_BUT,
   output logic       o_Busy,
   output logic       o_Done,
   output logic [1:0] o_Dbg_State
);

   localparam int GAP_W  = GAP_BITS + 1;
   localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
   localparam int EDGE_W = 5;

   localparam logic [EDGE_W-1:0] EDGE_TOTAL  = EDGE_W'(2 * BOUNCES + 1);
   localparam logic [SET_W-1:0]  SETTLE_INIT = SET_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BOUNCE = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic [15:0]         lfsr_q,   lfsr_d;
   logic [GAP_W-1:0]    gap_q,    gap_d;
   logic [EDGE_W-1:0]   edge_q,   edge_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic                but_q,    but_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;
   logic                target_q, target_d;

   logic [15:0]         lfsr_step;
   logic [GAP_W-1:0]    gap_load;

   // The LFSR only advances together with a gap load, so every burst is a pure
   // function of how many gaps have been drawn since reset.
   assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign gap_load  = {1'b0, lfsr_q[GAP_BITS-1:0]} + GAP_W'(1);

   // Request handshake: i_Start is a one-cycle request sampled every edge and taken
   // only in IDLE; o_Busy covers the accepted request and o_Done is its one-cycle ack.
   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      gap_d    = gap_q;
      edge_d   = edge_q;
      settle_d = settle_q;
      but_d    = but_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      target_d = target_q;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (i_Start) begin
               busy_d = 1'b1;
               if (i_Level != but_q) begin
                  target_d = i_Level;
                  edge_d   = EDGE_TOTAL;
                  gap_d    = gap_load;
                  lfsr_d   = lfsr_step;
                  state_d  = S_BOUNCE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         S_BOUNCE: begin
            if (gap_q <= GAP_W'(1)) begin
               but_d  = ~but_q;
               edge_d = edge_q - EDGE_W'(1);
               if (edge_q == EDGE_W'(1)) begin
                  settle_d = SETTLE_INIT;
                  state_d  = S_SETTLE;
               end else begin
                  gap_d  = gap_load;
                  lfsr_d = lfsr_step;
               end
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end

         S_SETTLE: begin
            // Odd toggle count already landed on the target; pin it explicitly anyway.
            but_d = target_q;
            if (settle_q <= SET_W'(1)) begin
               settle_d = '0;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (i_RST) begin
         state_q  <= S_IDLE;
         lfsr_q   <= LFSR_SEED;
         gap_q    <= '0;
         edge_q   <= '0;
         settle_q <= '0;
         but_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         target_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         gap_q    <= gap_d;
         edge_q   <= edge_d;
         settle_q <= settle_d;
         but_q    <= but_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         target_q <= target_d;
      end
   end

   assign o_BUT       = but_q;
   assign o_Busy      = busy_q;
   assign o_Done      = done_q;
   assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: a small-parameter instance checked cycle by cycle against a
// gap-list model, and a larger instance feeding a behavioural debouncer.
module tb_bounce_gen;

   localparam int A_B = 1;
   localparam int A_G = 3;
   localparam int A_S = 10;
   localparam int B_B = 3;
   localparam int B_G = 8;
   localparam int B_S = 400;
   localparam int DEB_N = 300;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_rst, a_start, a_level, a_but, a_busy, a_done;
   logic b_rst, b_start, b_level, b_but, b_busy, b_done;
   logic [1:0] a_state, b_state;

   int total = 0;
   int bad = 0;

   logic [15:0] ma_lfsr, mb_lfsr;
   logic ma_but, mb_but;
   logic [15:0] exp_q[$];

   logic deb;
   int deb_stable;
   int deb_changes;

   bounce_gen #(.BOUNCES(A_B), .GAP_BITS(A_G), .SETTLE_CYCLES(A_S), .LFSR_SEED(SEED)) dut_a (
      .CLK(clk), .i_RST(a_rst), .i_Start(a_start), .i_Level(a_level),
      .o_BUT(a_but), .o_Busy(a_busy), .o_Done(a_done), .o_Dbg_State(a_state)
   );

   bounce_gen #(.BOUNCES(B_B), .GAP_BITS(B_G), .SETTLE_CYCLES(B_S), .LFSR_SEED(SEED)) dut_b (
      .CLK(clk), .i_RST(b_rst), .i_Start(b_start), .i_Level(b_level),
      .o_BUT(b_but), .o_Busy(b_busy), .o_Done(b_done), .o_Dbg_State(b_state)
   );

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   function automatic int gap_of(input logic [15:0] x, input int bits);
      int m;
      m = (1 << bits) - 1;
      return (int'(x) & m) + 1;
   endfunction

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1;
      a_start = 1'b0; b_start = 1'b0;
      a_level = 1'b0; b_level = 1'b0;
      repeat (3) @(negedge clk);
      a_rst = 1'b0; b_rst = 1'b0;
      ma_lfsr = SEED; mb_lfsr = SEED;
      ma_but = 1'b0; mb_but = 1'b0;
      deb = 1'b0; deb_stable = 0; deb_changes = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         total++;
         if ({a_but, a_busy, a_done, b_but, b_busy, b_done} !== 6'b0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got a=%b%b%b b=%b%b%b exp=000 000", i,
                     a_but, a_busy, a_done, b_but, b_busy, b_done);
         end
      end
   endtask

   // Fixed waveform from seed ACE1: gaps 2,4,8 -> toggles at +2,+6,+14, done at +24.
   task automatic test_basic();
      int tq[$];
      int exp_t[3];
      int done_k;
      logic prev;
      exp_t = '{2, 6, 14};
      done_k = -1;
      a_start = 1'b1; a_level = 1'b1;
      prev = a_but;
      @(negedge clk);
      a_start = 1'b0;
      for (int k = 0; k <= 30; k++) begin
         if (k > 0) @(negedge clk);
         if (a_but !== prev) tq.push_back(k);
         prev = a_but;
         if (a_done === 1'b1 && done_k < 0) done_k = k;
         total++;
         if (a_busy !== (k < 24)) begin
            bad++;
            $display("FAIL basic_busy k=%0d got=%b exp=%b", k, a_busy, (k < 24));
         end
      end
      total++;
      if (tq.size() != 3) begin
         bad++;
         $display("FAIL basic_toggle_count got=%0d exp=3", tq.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (tq[i] != exp_t[i]) begin
               bad++;
               $display("FAIL basic_toggle_time idx=%0d got=%0d exp=%0d", i, tq[i], exp_t[i]);
            end
         end
      end
      total++;
      if (done_k != 24) begin
         bad++;
         $display("FAIL basic_done_time got=%0d exp=24", done_k);
      end
      total++;
      if (a_but !== 1'b1) begin
         bad++;
         $display("FAIL basic_final_level got=%b exp=1", a_but);
      end
      for (int i = 0; i < 3; i++) ma_lfsr = lfsr_next(ma_lfsr);
      ma_but = 1'b1;
   endtask

   // One request on dut_a checked every cycle against the model's toggle list.
   // chain leaves i_Start high at the end so the next call is accepted right after o_Done.
   task automatic run_a(input logic level, input bit disturb, input bit chain);
      int tt[$];
      int d;
      int kmax;
      int t_last;
      logic cur, eb, ebusy, edone;
      logic [15:0] x;
      cur = ma_but;
      x = ma_lfsr;
      d = 0;
      if (level != cur) begin
         for (int i = 0; i < 2 * A_B + 1; i++) begin
            d += gap_of(x, A_G);
            x = lfsr_next(x);
            tt.push_back(d);
         end
         d += A_S;
      end
      t_last = (tt.size() > 0) ? tt[tt.size() - 1] : 0;
      kmax = chain ? d : d + 1;
      a_start = 1'b1; a_level = level;
      @(negedge clk);
      for (int k = 0; k <= kmax; k++) begin
         if (k > 0) @(negedge clk);
         eb = cur;
         foreach (tt[i]) if (tt[i] <= k) eb = ~eb;
         ebusy = (k == 0) || (k < d);
         edone = (k == d);
         total++;
         if ({a_but, a_busy, a_done} !== {eb, ebusy, edone}) begin
            bad++;
            $display("FAIL run_a lvl=%b k=%0d got but/busy/done=%b%b%b exp=%b%b%b", level, k,
                     a_but, a_busy, a_done, eb, ebusy, edone);
         end
         if (chain) begin
            a_start = 1'b1;
         end else if (disturb && k < t_last && $urandom_range(0, 1) == 1) begin
            a_start = 1'b1;
            a_level = ~level;
         end else begin
            a_start = 1'b0;
         end
      end
      ma_but = level;
      ma_lfsr = x;
   endtask

   task automatic test_disturb();
      run_a(~ma_but, 1'b1, 1'b0);
      run_a(~ma_but, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_a(~ma_but, 1'b0, 1'b1);
      run_a(~ma_but, 1'b0, 1'b1);
      run_a(ma_but, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_burst();
      int g0;
      if (ma_but == 1'b1) run_a(1'b0, 1'b0, 1'b0);
      g0 = gap_of(ma_lfsr, A_G);
      a_start = 1'b1; a_level = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      repeat (g0) @(negedge clk);
      total++;
      if ({a_but, a_busy} !== 2'b11) begin
         bad++;
         $display("FAIL mid_first_toggle got but/busy=%b%b exp=11", a_but, a_busy);
      end
      a_rst = 1'b1;
      @(negedge clk);
      a_rst = 1'b0;
      total++;
      if ({a_but, a_busy, a_done} !== 3'b000) begin
         bad++;
         $display("FAIL mid_reset_edge got=%b%b%b exp=000", a_but, a_busy, a_done);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         total++;
         if ({a_but, a_busy, a_done} !== 3'b000) begin
            bad++;
            $display("FAIL mid_after_reset cyc=%0d got=%b%b%b exp=000", i, a_but, a_busy, a_done);
         end
      end
      ma_lfsr = SEED;
      ma_but = 1'b0;
   endtask

   task automatic test_equal();
      run_a(ma_but, 1'b0, 1'b0);
      run_a(ma_but, 1'b0, 1'b0);
   endtask

   task automatic deb_step();
      if (b_but !== deb) deb_stable++;
      else deb_stable = 0;
      if (deb_stable >= DEB_N) begin
         deb = b_but;
         deb_stable = 0;
         deb_changes++;
      end
   endtask

   task automatic test_debounce_loop();
      logic level, prev;
      logic [15:0] x;
      int last, n_tog, done_k, g, e, ch0, exp_ch, budget;
      budget = (2 * B_B + 1) * (1 << B_G) + B_S + 5;
      for (int r = 0; r < 20; r++) begin
         level = 1'($urandom_range(0, 1));
         ch0 = deb_changes;
         exp_ch = (level != mb_but) ? 1 : 0;
         exp_q.delete();
         x = mb_lfsr;
         if (level != mb_but) begin
            for (int i = 0; i < 2 * B_B + 1; i++) begin
               exp_q.push_back(16'(gap_of(x, B_G)));
               x = lfsr_next(x);
            end
         end
         b_start = 1'b1; b_level = level;
         prev = b_but;
         @(negedge clk);
         deb_step();
         b_start = 1'b0;
         last = 0; n_tog = 0; done_k = -1;
         if (level == mb_but) begin
            total++;
            if ({b_but, b_busy, b_done} !== {level, 1'b1, 1'b1}) begin
               bad++;
               $display("FAIL deb_equal r=%0d got=%b%b%b exp=%b11", r, b_but, b_busy, b_done, level);
            end
            @(negedge clk);
            deb_step();
         end else begin
            for (int k = 1; k <= budget; k++) begin
               @(negedge clk);
               deb_step();
               if (b_but !== prev) begin
                  n_tog++;
                  g = k - last;
                  last = k;
                  prev = b_but;
                  total++;
                  if (exp_q.size() == 0) begin
                     bad++;
                     $display("FAIL deb_extra_toggle r=%0d got gap=%0d exp=none", r, g);
                  end else begin
                     e = int'(exp_q.pop_front());
                     if (g != e) begin
                        bad++;
                        $display("FAIL deb_gap r=%0d idx=%0d got=%0d exp=%0d", r, n_tog - 1, g, e);
                     end
                  end
                  total++;
                  if (g < 1 || g > (1 << B_G)) begin
                     bad++;
                     $display("FAIL deb_gap_range r=%0d got=%0d exp=1..%0d", r, g, 1 << B_G);
                  end
               end
               if (b_done === 1'b1) begin
                  done_k = k;
                  break;
               end
            end
            total++;
            if (n_tog != 2 * B_B + 1) begin
               bad++;
               $display("FAIL deb_toggle_count r=%0d got=%0d exp=%0d", r, n_tog, 2 * B_B + 1);
            end
            total++;
            if (done_k != last + B_S) begin
               bad++;
               $display("FAIL deb_done_time r=%0d got=%0d exp=%0d", r, done_k, last + B_S);
            end
         end
         total++;
         if (b_but !== level || deb !== level) begin
            bad++;
            $display("FAIL deb_final_level r=%0d got but=%b deb=%b exp=%b", r, b_but, deb, level);
         end
         total++;
         if (deb_changes - ch0 != exp_ch) begin
            bad++;
            $display("FAIL deb_transitions r=%0d got=%0d exp=%0d", r, deb_changes - ch0, exp_ch);
         end
         mb_but = level;
         mb_lfsr = x;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_disturb();
      test_back_to_back();
      test_reset_mid_burst();
      test_equal();
      test_basic();
      test_debounce_loop();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
